// File: rtl/falcon_pkg.sv
// ---------------------------------------------------------------------------
// falcon_pkg
//   Shared constants for the Falcon accumulator ALU tile.
//   - OP_*  : 4-bit opcodes presented on uio_in[3:0].
//   - FLG_* : bit positions of the status flags inside the 4-bit flag nibble
//             that is driven on uio_out[7:4].
// ---------------------------------------------------------------------------
package falcon_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SBB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_ROL = 4'hC;
  localparam logic [3:0] OP_ROR = 4'hD;
  localparam logic [3:0] OP_INC = 4'hE;
  localparam logic [3:0] OP_CLR = 4'hF;

  // Flag nibble layout; bit 3 lands on uio_out[7].
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

endpackage

// File: rtl/falcon_alu.sv
// ---------------------------------------------------------------------------
// falcon_alu
//   Purely combinational 8-bit ALU core of the Falcon tile.
//   Ports:
//     a_i      8  accumulator (current A)
//     b_i      8  operand B
//     cin_i    1  current carry flag
//     op_i     4  opcode
//     result_o 8  new accumulator value
//     c_o      1  carry / borrow out (0 for logical ops, LD and CLR)
//     v_o      1  signed overflow (arithmetic ops only)
// ---------------------------------------------------------------------------
module falcon_alu
  import falcon_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  input  logic [3:0] op_i,
  output logic [7:0] result_o,
  output logic       c_o,
  output logic       v_o
);

  // 9-bit scratch: bit 8 is carry-out for adds and borrow for subtracts,
  // since a negative difference wraps with bit 8 set.
  logic [8:0] wide;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    wide     = '0;
    result_o = a_i;
    c_o      = 1'b0;
    v_o      = 1'b0;

    unique case (op_i)
      OP_NOP: result_o = a_i;
      OP_LD:  result_o = b_i;
      OP_ADD, OP_ADC: begin
        wide     = {1'b0, a_i} + {1'b0, b_i}
                 + {8'b0, (op_i == OP_ADC) ? cin_i : 1'b0};
        result_o = wide[7:0];
        c_o      = wide[8];
        // Overflow: operands share a sign that the result does not.
        v_o      = (a_i[7] == b_i[7]) && (wide[7] != a_i[7]);
      end
      OP_SUB, OP_SBB: begin
        wide     = {1'b0, a_i} - {1'b0, b_i}
                 - {8'b0, (op_i == OP_SBB) ? cin_i : 1'b0};
        result_o = wide[7:0];
        c_o      = wide[8];
        // Overflow: operands differ in sign and the result flipped from A.
        v_o      = (a_i[7] != b_i[7]) && (wide[7] != a_i[7]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: begin result_o = {a_i[6:0], 1'b0};   c_o = a_i[7]; end
      OP_SHR: begin result_o = {1'b0, a_i[7:1]};   c_o = a_i[0]; end
      OP_ROL: begin result_o = {a_i[6:0], a_i[7]}; c_o = a_i[7]; end
      OP_ROR: begin result_o = {a_i[0], a_i[7:1]}; c_o = a_i[0]; end
      OP_INC: begin
        result_o = a_i + 8'd1;
        c_o      = (a_i == 8'hFF);
        v_o      = (a_i == 8'h7F);
      end
      OP_CLR: result_o = 8'h00;
      default: result_o = a_i;
    endcase
  end

endmodule

// File: rtl/tt_um_falcon.sv
// ---------------------------------------------------------------------------
// tt_um_falcon
//   Falcon 8-bit accumulator ALU tile for the TinyTapeout harness. One
//   opcode executes per enabled clock; results are fully registered.
//   Ports:
//     clk      1  system clock, rising edge
//     rst      1  synchronous reset, active-high (overrides ena and opcode)
//     ena      1  tile enable; 0 holds all state
//     ui_in    8  operand B
//     uio_in   8  [3:0] opcode; [7:4] unused
//     uo_out   8  accumulator A
//     uio_out  8  [7]=Z [6]=C [5]=V [4]=N; [3:0]=0
//     uio_oe   8  constant 8'hF0 (upper nibble are outputs)
// ---------------------------------------------------------------------------
module tt_um_falcon
  import falcon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] a_q, a_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] op;
  logic [7:0] alu_result;
  logic       alu_c;
  logic       alu_v;

  assign op = uio_in[3:0];

  // The upper uio_in bits are the tile's output pins and carry no input.
  logic unused_uio_in;
  assign unused_uio_in = &{1'b0, uio_in[7:4]};

  falcon_alu u_alu (
    .a_i      (a_q),
    .b_i      (ui_in),
    .cin_i    (flags_q[FLG_C]),
    .op_i     (op),
    .result_o (alu_result),
    .c_o      (alu_c),
    .v_o      (alu_v)
  );

  always_comb begin
    a_d            = alu_result;
    flags_d        = '0;
    flags_d[FLG_Z] = (alu_result == 8'h00);
    flags_d[FLG_C] = alu_c;
    flags_d[FLG_V] = alu_v;
    flags_d[FLG_N] = alu_result[7];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, which is what lets ops chain each cycle.
    if (rst) begin
      a_q     <= '0;
      flags_q <= '0;
    end else if (ena && (op != OP_NOP)) begin
      a_q     <= a_d;
      flags_q <= flags_d;
    end
  end

  assign uo_out  = a_q;
  assign uio_out = {flags_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_falcon.sv
// ---------------------------------------------------------------------------
// tb_tt_um_falcon
//   Directed self-checking bench for the Falcon accumulator tile. Expected
//   values are hand-computed; uio_out flag nibble is {Z,C,V,N}.
// ---------------------------------------------------------------------------
module tb_tt_um_falcon;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  tt_um_falcon dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Present one op, clock it, then settle 1 time unit past the edge.
  task automatic step(input logic [3:0] op, input logic [7:0] b);
    uio_in = {4'b0000, op};
    ui_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; ui_in = 8'hAA; uio_in = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (uo_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_acc: got %h want 00", uo_out);
    end
    n_tests++;
    if (uio_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %h want 00", uio_out);
    end
    n_tests++;
    if (uio_oe !== 8'hF0) begin
      n_fail++; $display("FAIL reset_oe: got %h want F0", uio_oe);
    end
    rst = 1'b0;
  endtask

  task automatic test_overflow();
    step(4'h1, 8'h7F);   // LD 7F
    n_tests++;
    if ({uo_out, uio_out} !== 16'h7F00) begin
      n_fail++; $display("FAIL ld_7f: got %h want 7F00", {uo_out, uio_out});
    end
    step(4'hE, 8'h00);   // INC -> 80, V=1 N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h8030) begin
      n_fail++; $display("FAIL inc_7f: got %h want 8030", {uo_out, uio_out});
    end
    // Upper uio_in bits set to prove they are ignored.
    uio_in = 8'hF2; ui_in = 8'hFF;   // ADD FF -> 7F, C=1 V=1
    @(posedge clk); #1;
    n_tests++;
    if ({uo_out, uio_out} !== 16'h7F60) begin
      n_fail++; $display("FAIL add_ff: got %h want 7F60", {uo_out, uio_out});
    end
  endtask

  task automatic test_carry_chain();
    step(4'h1, 8'hFF);   // LD FF
    step(4'h2, 8'h01);   // ADD 01 -> 00, Z=1 C=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h00C0) begin
      n_fail++; $display("FAIL add_wrap: got %h want 00C0", {uo_out, uio_out});
    end
    step(4'h3, 8'h00);   // ADC 00 -> 01, C=0
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0100) begin
      n_fail++; $display("FAIL adc_cin: got %h want 0100", {uo_out, uio_out});
    end
    step(4'h1, 8'h00);   // LD 00 -> Z=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0080) begin
      n_fail++; $display("FAIL ld_00: got %h want 0080", {uo_out, uio_out});
    end
    step(4'h4, 8'h01);   // SUB 01 -> FF, C=1 N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'hFF50) begin
      n_fail++; $display("FAIL sub_borrow: got %h want FF50", {uo_out, uio_out});
    end
    step(4'h5, 8'h00);   // SBB 00 -> FE, C=0 N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'hFE10) begin
      n_fail++; $display("FAIL sbb_cin: got %h want FE10", {uo_out, uio_out});
    end
    step(4'h1, 8'h80);   // LD 80
    step(4'h4, 8'h01);   // SUB 01 -> 7F, V=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h7F20) begin
      n_fail++; $display("FAIL sub_ovf: got %h want 7F20", {uo_out, uio_out});
    end
  endtask

  task automatic test_logic();
    step(4'h1, 8'hF0);   // LD F0
    step(4'h6, 8'h3C);   // AND -> 30
    n_tests++;
    if ({uo_out, uio_out} !== 16'h3000) begin
      n_fail++; $display("FAIL and_op: got %h want 3000", {uo_out, uio_out});
    end
    step(4'h7, 8'h81);   // OR -> B1, N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'hB110) begin
      n_fail++; $display("FAIL or_op: got %h want B110", {uo_out, uio_out});
    end
    step(4'h8, 8'hB1);   // XOR -> 00, Z=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0080) begin
      n_fail++; $display("FAIL xor_op: got %h want 0080", {uo_out, uio_out});
    end
    step(4'h9, 8'h00);   // NOT -> FF, N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'hFF10) begin
      n_fail++; $display("FAIL not_op: got %h want FF10", {uo_out, uio_out});
    end
    step(4'hC, 8'h00);   // ROL FF -> FF, C=1 N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'hFF50) begin
      n_fail++; $display("FAIL rol_op: got %h want FF50", {uo_out, uio_out});
    end
    step(4'hF, 8'h55);   // CLR -> 00, Z=1, C cleared
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0080) begin
      n_fail++; $display("FAIL clr_op: got %h want 0080", {uo_out, uio_out});
    end
  endtask

  task automatic test_shift_rotate();
    step(4'h1, 8'h81);   // LD 81
    step(4'hA, 8'h00);   // SHL -> 02, C=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0240) begin
      n_fail++; $display("FAIL shl_op: got %h want 0240", {uo_out, uio_out});
    end
    step(4'hD, 8'h00);   // ROR -> 01, C=0
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0100) begin
      n_fail++; $display("FAIL ror_op1: got %h want 0100", {uo_out, uio_out});
    end
    step(4'hD, 8'h00);   // ROR -> 80, C=1 N=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h8050) begin
      n_fail++; $display("FAIL ror_op2: got %h want 8050", {uo_out, uio_out});
    end
    step(4'hB, 8'h00);   // SHR -> 40, C=0
    n_tests++;
    if ({uo_out, uio_out} !== 16'h4000) begin
      n_fail++; $display("FAIL shr_op: got %h want 4000", {uo_out, uio_out});
    end
  endtask

  task automatic test_hold();
    step(4'h1, 8'h5A);   // LD 5A
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(4'h2, 8'h11); // ADD while disabled
      n_tests++;
      if ({uo_out, uio_out} !== 16'h5A00) begin
        n_fail++; $display("FAIL hold_ena%0d: got %h want 5A00", i, {uo_out, uio_out});
      end
    end
    ena = 1'b1;
    step(4'h2, 8'hA6);   // ADD A6 -> 00, Z=1 C=1
    n_tests++;
    if ({uo_out, uio_out} !== 16'h00C0) begin
      n_fail++; $display("FAIL hold_add: got %h want 00C0", {uo_out, uio_out});
    end
    step(4'h0, 8'h33);   // NOP holds A and flags
    step(4'h0, 8'h44);
    n_tests++;
    if ({uo_out, uio_out} !== 16'h00C0) begin
      n_fail++; $display("FAIL hold_nop: got %h want 00C0", {uo_out, uio_out});
    end
    step(4'h3, 8'h00);   // ADC uses held C=1 -> 01
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0100) begin
      n_fail++; $display("FAIL nop_keeps_c: got %h want 0100", {uo_out, uio_out});
    end
  endtask

  task automatic test_reset_midstream();
    step(4'h1, 8'h10);   // LD 10
    step(4'h2, 8'h01);   // ADD -> 11
    n_tests++;
    if ({uo_out, uio_out} !== 16'h1100) begin
      n_fail++; $display("FAIL mid_pre: got %h want 1100", {uo_out, uio_out});
    end
    rst = 1'b1;
    step(4'h2, 8'hF0);   // reset wins over ADD
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++; $display("FAIL mid_rst: got %h want 0000", {uo_out, uio_out});
    end
    rst = 1'b0;
    step(4'h2, 8'h01);   // ops resume -> 01
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0100) begin
      n_fail++; $display("FAIL mid_resume: got %h want 0100", {uo_out, uio_out});
    end
    step(4'h2, 8'h01);   // -> 02
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0200) begin
      n_fail++; $display("FAIL mid_chain: got %h want 0200", {uo_out, uio_out});
    end
    // Reset also overrides a deasserted enable.
    ena = 1'b0; rst = 1'b1;
    step(4'h2, 8'h01);
    n_tests++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      n_fail++; $display("FAIL rst_no_ena: got %h want 0000", {uo_out, uio_out});
    end
    rst = 1'b0; ena = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    test_reset();
    test_overflow();
    test_carry_chain();
    test_logic();
    test_shift_rotate();
    test_hold();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
